// File: rtl/gan_pkg.sv
// rtl/gan_pkg.sv - shared constants, layer layout and state encoding for the GAN parameter loader
// Layer sizes of the 4-4-2-1-1-1-2-4-4 pipeline, flat word offsets of every
// weight/bias block inside param_bus, and the loader FSM encoding.
package gan_pkg;

    localparam int WIDTH = 16;

    // Neuron (output) and input counts per layer.
    localparam int L1_N_IN = 4;  localparam int L1_N_OUT = 4;
    localparam int L2_N_IN = 4;  localparam int L2_N_OUT = 2;
    localparam int L3_N_IN = 2;  localparam int L3_N_OUT = 1;
    localparam int L4_N_IN = 1;  localparam int L4_N_OUT = 1;
    localparam int L5_N_IN = 1;  localparam int L5_N_OUT = 1;
    localparam int L6_N_IN = 1;  localparam int L6_N_OUT = 2;
    localparam int L7_N_IN = 2;  localparam int L7_N_OUT = 4;
    localparam int L8_N_IN = 4;  localparam int L8_N_OUT = 4;

    // Word offsets: each layer is weights (neuron-major) followed by biases,
    // so every layer bus is one contiguous slice of param_bus.
    localparam int L1_W_OFF = 0;
    localparam int L1_B_OFF = L1_W_OFF + L1_N_OUT * L1_N_IN;   // 16
    localparam int L2_W_OFF = L1_B_OFF + L1_N_OUT;             // 20
    localparam int L2_B_OFF = L2_W_OFF + L2_N_OUT * L2_N_IN;   // 28
    localparam int L3_W_OFF = L2_B_OFF + L2_N_OUT;             // 30
    localparam int L3_B_OFF = L3_W_OFF + L3_N_OUT * L3_N_IN;   // 32
    localparam int L4_W_OFF = L3_B_OFF + L3_N_OUT;             // 33
    localparam int L4_B_OFF = L4_W_OFF + L4_N_OUT * L4_N_IN;   // 34
    localparam int L5_W_OFF = L4_B_OFF + L4_N_OUT;             // 35
    localparam int L5_B_OFF = L5_W_OFF + L5_N_OUT * L5_N_IN;   // 36
    localparam int L6_W_OFF = L5_B_OFF + L5_N_OUT;             // 37
    localparam int L6_B_OFF = L6_W_OFF + L6_N_OUT * L6_N_IN;   // 39
    localparam int L7_W_OFF = L6_B_OFF + L6_N_OUT;             // 41
    localparam int L7_B_OFF = L7_W_OFF + L7_N_OUT * L7_N_IN;   // 49
    localparam int L8_W_OFF = L7_B_OFF + L7_N_OUT;             // 53
    localparam int L8_B_OFF = L8_W_OFF + L8_N_OUT * L8_N_IN;   // 69

    localparam int N_WORDS = L8_B_OFF + L8_N_OUT;              // 73
    localparam int CNT_W   = $clog2(N_WORDS);                  // 7

    // Bit position of flat word k inside param_bus.
    function automatic int word_lsb(input int k);
        return k * WIDTH;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/gan_param_bank.sv
// rtl/gan_param_bank.sv - shadow/active parameter register banks with atomic commit
// Ports: clk, rst (async active-low); wr_en/wr_addr/wr_data write one shadow
// word; commit copies the shadow bank into the active bank, forwarding a
// same-cycle write so the final word lands in the same edge; active_bus is
// the flattened active bank.
module gan_param_bank
    import gan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CNT_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     commit,
    output logic [WIDTH*N_WORDS-1:0] active_bus
);

    logic [WIDTH-1:0] shadow [N_WORDS];
    logic [WIDTH-1:0] active [N_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_WORDS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (wr_en && wr_addr == CNT_W'(k)) begin
                    shadow[k] <= wr_data;
                end
            end
        end
    end

    // The word written on the commit edge is not yet in shadow, so bypass it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_WORDS; k++) begin
                active[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < N_WORDS; k++) begin
                active[k] <= (wr_en && wr_addr == CNT_W'(k)) ? wr_data : shadow[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_WORDS; g++) begin : g_flat
            assign active_bus[g*WIDTH +: WIDTH] = active[g];
        end
    endgenerate

endmodule

// File: rtl/gan_param_loader.sv
// rtl/gan_param_loader.sv - framed stream loader filling the GAN weight/bias set
// Ports: clk, rst (async active-low); load_start restarts a frame;
// s_valid/s_ready/s_data/s_last form the word stream; param_bus is the
// committed parameter set (word k at [k*WIDTH +: WIDTH]); params_valid,
// load_busy, load_err and word_cnt report loader status.
module gan_param_loader
    import gan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    output logic [WIDTH*N_WORDS-1:0] param_bus,
    output logic                     params_valid,
    output logic                     load_busy,
    output logic                     load_err,
    output logic [CNT_W-1:0]         word_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q;
    logic             accept;
    logic             at_last_word;
    logic             commit;

    // A restart wins over a beat presented in the same cycle.
    assign s_ready      = (state_q == ST_LOAD) && !load_start;
    assign accept       = s_valid && s_ready;
    assign at_last_word = (cnt_q == CNT_W'(N_WORDS - 1));
    assign commit       = accept && at_last_word && s_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (at_last_word) begin
                state_d = s_last ? ST_DONE : ST_ERR;
            end else if (s_last) begin
                state_d = ST_ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                valid_q <= 1'b1;
            end
        end
    end

    gan_param_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (accept),
        .wr_addr    (cnt_q),
        .wr_data    (s_data),
        .commit     (commit),
        .active_bus (param_bus)
    );

    assign params_valid = valid_q;
    assign load_busy    = (state_q == ST_LOAD);
    assign load_err     = (state_q == ST_ERR);
    assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_gan_param_loader.sv
// tb/tb_gan_param_loader.sv - self-checking bench for gan_param_loader
module tb_gan_param_loader;
    import gan_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     load_start = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic [WIDTH-1:0]         s_data = '0;
    logic                     s_last = 1'b0;
    logic [WIDTH*N_WORDS-1:0] param_bus;
    logic                     params_valid;
    logic                     load_busy;
    logic                     load_err;
    logic [CNT_W-1:0]         word_cnt;

    gan_param_loader dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .param_bus    (param_bus),
        .params_valid (params_valid),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame-level view of the loader.
    logic [WIDTH-1:0] m_shadow [N_WORDS];
    logic [WIDTH-1:0] m_active [N_WORDS];
    bit               m_valid;
    bit               m_busy;
    bit               m_err;
    int               m_cnt;

    task automatic m_reset();
        for (int k = 0; k < N_WORDS; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_valid = 0; m_busy = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic m_start();
        m_busy = 1; m_err = 0; m_cnt = 0;
    endtask

    task automatic m_beat(input logic [WIDTH-1:0] d, input bit last);
        int c;
        c = m_cnt;
        m_shadow[c] = d;
        m_cnt = c + 1;
        if (c == N_WORDS - 1) begin
            m_busy = 0;
            if (last) begin
                for (int k = 0; k < N_WORDS; k++) m_active[k] = m_shadow[k];
                m_valid = 1;
            end else begin
                m_err = 1;
            end
        end else if (last) begin
            m_busy = 0;
            m_err  = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag);
        logic [WIDTH*N_WORDS-1:0] exp;
        int bad;
        for (int k = 0; k < N_WORDS; k++) exp[word_lsb(k) +: WIDTH] = m_active[k];
        checks++;
        assert (param_bus === exp) else begin
            errors++;
            bad = 0;
            for (int k = N_WORDS - 1; k >= 0; k--)
                if (param_bus[word_lsb(k) +: WIDTH] !== exp[word_lsb(k) +: WIDTH]) bad = k;
            $error("FAIL %s param_bus word %0d observed=%h expected=%h", tag, bad,
                   param_bus[word_lsb(bad) +: WIDTH], exp[word_lsb(bad) +: WIDTH]);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cnt"},   32'(word_cnt),     32'(m_cnt));
        chk({tag, "_valid"}, 32'(params_valid), 32'(m_valid));
        chk({tag, "_busy"},  32'(load_busy),    32'(m_busy));
        chk({tag, "_err"},   32'(load_err),     32'(m_err));
        chk_bus({tag, "_bus"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        s_valid    = 1'b0;
        tick();
        load_start = 1'b0;
        m_start();
    endtask

    // One accepted beat, preceded by random idle cycles when gap_pct > 0.
    task automatic beat(input logic [WIDTH-1:0] d, input bit last, input int gap_pct, input string tag);
        int idle;
        idle = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct && idle < 8) begin
            s_valid = 1'b0;
            tick();
            idle++;
            chk({tag, "_stall_cnt"}, 32'(word_cnt), 32'(m_cnt));
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        chk({tag, "_ready"}, 32'(s_ready), 32'(m_busy));
        tick();
        m_beat(d, last);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame_const(input logic [WIDTH-1:0] d, input int gap_pct, input string tag);
        for (int k = 0; k < N_WORDS; k++) beat(d, k == N_WORDS - 1, gap_pct, tag);
    endtask

    initial begin
        m_reset();

        // Reset state
        #1;
        chk_all("reset");
        chk("reset_ready", 32'(s_ready), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_all("idle");

        // 1: sequential data k+1, valid held high
        do_start();
        chk_all("s1_start");
        for (int k = 0; k < N_WORDS; k++) beat(WIDTH'(k + 1), k == N_WORDS - 1, 0, "s1");
        chk_all("s1_done");
        chk("s1_w0",  32'(param_bus[word_lsb(0) +: WIDTH]),  32'h0001);
        chk("s1_w72", 32'(param_bus[word_lsb(72) +: WIDTH]), 32'h0049);

        // 2: early s_last on beat 10
        do_start();
        for (int k = 0; k <= 10; k++) beat(WIDTH'($urandom), k == 10, 0, "s2");
        chk_all("s2_err");
        chk("s2_cnt11", 32'(word_cnt), 32'd11);
        // Beats in ERR are refused
        s_valid = 1'b1; s_data = 16'h1234;
        #1;
        chk("s2_err_ready", 32'(s_ready), 32'd0);
        tick();
        s_valid = 1'b0;
        chk_all("s2_hold");

        // 3: missing s_last on the final word
        do_start();
        for (int k = 0; k < N_WORDS; k++) beat(WIDTH'($urandom), 1'b0, 0, "s3");
        chk_all("s3_err");
        do_start();
        chk_all("s3_restart");

        // 4: 0x8000 everywhere with ~50% valid gaps
        frame_const(16'h8000, 50, "s4");
        chk_all("s4_done");

        // Random data frame with gaps
        do_start();
        for (int k = 0; k < N_WORDS; k++) beat(WIDTH'($urandom), k == N_WORDS - 1, 30, "rnd");
        chk_all("rnd_done");

        // 5: restart on beat 40 while s_valid is high
        do_start();
        for (int k = 0; k < 40; k++) beat(WIDTH'($urandom), 1'b0, 20, "s5a");
        chk_all("s5_mid");
        s_valid = 1'b1; s_data = 16'hDEAD; s_last = 1'b0; load_start = 1'b1;
        #1;
        chk("s5_ready_blocked", 32'(s_ready), 32'd0);
        tick();
        load_start = 1'b0; s_valid = 1'b0;
        m_start();
        chk_all("s5_restart");
        frame_const(16'h7FFF, 0, "s5b");
        chk_all("s5_done");

        // 6: asynchronous reset mid-frame
        do_start();
        for (int k = 0; k < 30; k++) beat(WIDTH'($urandom), 1'b0, 0, "s6");
        chk_all("s6_mid");
        s_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        chk_all("s6_async");
        chk("s6_ready", 32'(s_ready), 32'd0);
        #1;
        rst = 1'b1;
        tick();
        chk_all("s6_idle");
        chk("s6_idle_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;

        // Recovery after reset
        do_start();
        for (int k = 0; k < N_WORDS; k++) beat(WIDTH'($urandom), k == N_WORDS - 1, 10, "post");
        chk_all("post_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gan_param_loader.md
Name: gan_param_loader

Overview:
Streaming writer that fills the full weight/bias set consumed by the 8-layer GAN pipeline top (4-4-2-1-1-1-2-4-4). It accepts 16-bit signed Q-format words over a valid/ready stream into a shadow bank. On a correctly framed final word it commits the shadow bank atomically to an active bank that drives the pipeline's parameter buses. The pipeline never sees a partially updated parameter set.

Parameters:
WIDTH, 16, bits per parameter word (signed)
N_WORDS, 73, total parameter words per frame (sum of all layer weights and biases)
CNT_W, 7, word counter width, equal to $clog2(N_WORDS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
load_start  in  1  single-cycle pulse; begins or restarts a frame load
s_valid  in  1  stream word valid
s_ready  out  1  stream ready; beat accepted when s_valid & s_ready
s_data  in  WIDTH  parameter word, signed
s_last  in  1  marks the final word of the frame
param_bus  out  WIDTH*N_WORDS  active bank; word k at bits [k*WIDTH +: WIDTH]
params_valid  out  1  high once at least one frame has committed since reset
load_busy  out  1  high in LOAD state
load_err  out  1  sticky framing error
word_cnt  out  CNT_W  words accepted in the current frame

Behaviour:
- Reset (rst=0, async): state IDLE. Shadow and active banks cleared to 0. All outputs are 0, including params_valid, load_err, word_cnt and s_ready.
- States: IDLE, LOAD, DONE, ERR.
- Any state, load_start=1: next state is LOAD, word_cnt cleared to 0, load_err cleared. The active bank and params_valid are unchanged.
- s_ready = (state==LOAD) & ~load_start, combinationally. A beat presented in the same cycle as load_start is therefore never accepted.
- LOAD, accepted beat at count c:
  - shadow[c] <= s_data and word_cnt <= c+1.
  - If c<N_WORDS-1 and s_last=1: go to ERR.
  - If c=N_WORDS-1 and s_last=0: go to ERR.
  - If c=N_WORDS-1 and s_last=1: commit. On the same edge, the active bank takes the shadow bank with word N_WORDS-1 replaced by s_data. params_valid <= 1, state goes to DONE.
- Commit latency: param_bus shows the new set in the cycle after the final handshake.
- DONE and ERR hold until load_start. In ERR, load_err=1, the active bank keeps the previous committed set, and params_valid keeps its prior value.
- Stalls: s_valid low in LOAD holds all state; there is no timeout.
- The shadow bank is not cleared on restart. Stale words are always overwritten before any commit, since a commit requires all N_WORDS words.
- Reset asserted mid-frame: everything clears immediately, and params_valid drops to 0. The downstream pipeline must treat its output as invalid.
- No arithmetic is performed. Words are stored bit-exact and are not sign-extended or saturated.

Word ordering within a frame (flat index k):
- Layers in order L1..L8, each as weights then biases.
- A weight block is ordered neuron-major: k = off + neuron*N_in + input.
- Offsets: L1_W 0, L1_B 16, L2_W 20, L2_B 28, L3_W 30, L3_B 32, L4_W 33, L4_B 34, L5_W 35, L5_B 36, L6_W 37, L6_B 39, L7_W 41, L7_B 49, L8_W 53, L8_B 69, total 73.
- With this ordering each layer's weight/bias bus is a contiguous slice of param_bus.

Decomposition:
- Shared package (gan_pkg):
  - WIDTH and N_WORDS.
  - All sixteen layer offset constants above, plus per-layer neuron and input counts.
  - State encoding localparams.
  - The top-level slices param_bus using these same constants.
- Sub-module gan_param_bank:
  - Holds the shadow and active register arrays, with write-enable, write address and a commit strobe.
  - The FSM, counter and handshake logic stay in gan_param_loader.

Test Plan:
1. Reset, then load_start, then 73 beats with s_data=k+1 (k=0..72), s_valid held high and s_last on beat 72 -> s_ready=1 throughout. param_bus word 0=0x0001 and word 72=0x0049 in the cycle after beat 72. params_valid=1, load_busy=0.
2. After a good frame, load_start then beats with s_last on beat 10 -> load_err=1, state ERR, word_cnt=11. param_bus still equals the scenario-1 values, params_valid=1.
3. Frame of 73 beats with s_last=0 on beat 72 -> load_err=1 and no commit. A following load_start clears load_err in the next cycle.
4. Random s_valid gaps (about 50% duty) over a full frame with s_data=0x8000 (-32768) on all words -> every word of param_bus equals 0x8000. word_cnt advances only on handshakes.
5. load_start asserted at beat 40 while s_valid=1 -> that beat is not accepted (s_ready=0 that cycle) and word_cnt=0 next cycle. A following full 73-beat frame with s_data=0x7FFF commits all words as 0x7FFF.
6. rst pulsed low for one cycle mid-frame at beat 30, asynchronously between clock edges -> all outputs are 0 immediately, including params_valid and param_bus, and the state is IDLE.
